// File: rtl/hist_bin_ctrl.sv
// Histogram bin RAM controller: arbitrates kernel increments, host readout and bulk clear.
// Optional HIST_SAT_EN: bins and total_cnt saturate instead of wrapping.
module hist_bin_ctrl #(
  parameter int unsigned BIN_ADDR_W = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_BINS   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_valid,
  input  logic [BIN_ADDR_W-1:0] inc_bin,
  output logic                  inc_ready,
  input  logic                  host_rd_req,
  input  logic [BIN_ADDR_W-1:0] host_rd_addr,
  output logic                  host_rd_ready,
  output logic                  host_rd_valid,
  output logic [CNT_W-1:0]      host_rd_data,
  input  logic                  clear_start,
  output logic                  clear_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      total_cnt,
  output logic [BIN_ADDR_W-1:0] ram_raddr,
  input  logic [CNT_W-1:0]      ram_rdata,
  output logic [BIN_ADDR_W-1:0] ram_waddr,
  output logic [CNT_W-1:0]      ram_wdata,
  output logic                  ram_wen
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                  state;
  logic                    s1_valid;
  logic [BIN_ADDR_W-1:0]   s1_bin;
  logic                    rd_pend;
  logic [BIN_ADDR_W-1:0]   rd_addr_q;
  logic [CNT_W-1:0]        rd_hold;
  logic                    fwd_valid;
  logic [BIN_ADDR_W-1:0]   fwd_addr;
  logic [CNT_W-1:0]        fwd_data;
  logic [BIN_ADDR_W-1:0]   clr_addr;
  logic [BIN_ADDR_W-1:0]   raddr_q;

  logic                    idle_c;
  logic                    clr_go_c;
  logic                    host_acc_c;
  logic                    inc_acc_c;
  logic [CNT_W-1:0]        s1_base_c;
  logic [CNT_W-1:0]        rd_base_c;
  logic [CNT_W-1:0]        inc_val_c;

  // Arbitration, read issue, forwarding and write datapath for the current cycle.
  // RAM read data lands the cycle after issue, so these paths are combinational.
  always_comb begin
    idle_c        = 1'b0;
    clr_go_c      = 1'b0;
    host_rd_ready = 1'b0;
    inc_ready     = 1'b0;
    host_acc_c    = 1'b0;
    inc_acc_c     = 1'b0;
    ram_raddr     = '0;
    ram_wen       = 1'b0;
    ram_waddr     = '0;
    ram_wdata     = '0;
    host_rd_valid = 1'b0;
    host_rd_data  = '0;
    busy          = 1'b0;

    s1_base_c = (fwd_valid && fwd_addr == s1_bin)    ? fwd_data : ram_rdata;
    rd_base_c = (fwd_valid && fwd_addr == rd_addr_q) ? fwd_data : ram_rdata;
`ifdef HIST_SAT_EN
    inc_val_c = (s1_base_c == '1) ? s1_base_c : s1_base_c + CNT_W'(1);
`else
    inc_val_c = s1_base_c + CNT_W'(1);
`endif

    if (!rst) begin
      idle_c        = (state == IDLE);
      clr_go_c      = idle_c && clear_start;
      host_rd_ready = idle_c && !clear_start;
      inc_ready     = idle_c && !clear_start && !host_rd_req;
      host_acc_c    = host_rd_ready && host_rd_req;
      inc_acc_c     = inc_ready && inc_valid;

      ram_raddr = raddr_q;
      if (host_acc_c)     ram_raddr = host_rd_addr;
      else if (inc_acc_c) ram_raddr = inc_bin;

      // Idle write port keeps showing the last write, which the forward regs hold.
      ram_waddr = fwd_addr;
      ram_wdata = fwd_data;
      if (state == CLEAR) begin
        ram_wen   = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = '0;
      end else if (s1_valid) begin
        ram_wen   = 1'b1;
        ram_waddr = s1_bin;
        ram_wdata = inc_val_c;
      end

      host_rd_valid = rd_pend;
      host_rd_data  = rd_pend ? rd_base_c : rd_hold;
      busy          = (state != IDLE) || s1_valid;
    end
  end

  // Control FSM, increment stage S1, forwarding register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1_valid   <= 1'b0;
      s1_bin     <= '0;
      rd_pend    <= 1'b0;
      rd_addr_q  <= '0;
      rd_hold    <= '0;
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
      clr_addr   <= '0;
      raddr_q    <= '0;
      total_cnt  <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      raddr_q    <= ram_raddr;
      s1_valid   <= inc_acc_c;
      rd_pend    <= host_acc_c;
      fwd_valid  <= ram_wen;
      if (inc_acc_c)  s1_bin    <= inc_bin;
      if (host_acc_c) rd_addr_q <= host_rd_addr;
      if (rd_pend)    rd_hold   <= rd_base_c;
      if (ram_wen) begin
        fwd_addr <= ram_waddr;
        fwd_data <= ram_wdata;
      end
`ifdef HIST_SAT_EN
      if (inc_acc_c && total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
`else
      if (inc_acc_c) total_cnt <= total_cnt + CNT_W'(1);
`endif

      case (state)
        IDLE: begin
          if (clr_go_c) begin
            clr_addr  <= '0;
            total_cnt <= '0;
            state     <= s1_valid ? DRAIN : CLEAR;
          end
        end
        DRAIN: state <= CLEAR;
        CLEAR: begin
          clr_addr <= clr_addr + BIN_ADDR_W'(1);
          if (clr_addr == BIN_ADDR_W'(NUM_BINS - 1)) begin
            state      <= IDLE;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_bin_ctrl.sv
// Directed bench for hist_bin_ctrl with a behavioural read-before-write bin RAM.
module tb_hist_bin_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inc_valid;
  logic [7:0]  inc_bin;
  logic        inc_ready;
  logic        host_rd_req;
  logic [7:0]  host_rd_addr;
  logic        host_rd_ready;
  logic        host_rd_valid;
  logic [31:0] host_rd_data;
  logic        clear_start;
  logic        clear_done;
  logic        busy;
  logic [31:0] total_cnt;
  logic [7:0]  ram_raddr;
  logic [31:0] ram_rdata;
  logic [7:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic        ram_wen;

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sat_exp;

  always #5 clk = ~clk;

  // Registered-read RAM; the read samples the array before this edge's write.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end

  hist_bin_ctrl dut (
    .clk(clk), .rst(rst),
    .inc_valid(inc_valid), .inc_bin(inc_bin), .inc_ready(inc_ready),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_ready(host_rd_ready),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .clear_start(clear_start), .clear_done(clear_done), .busy(busy), .total_cnt(total_cnt),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Two-cycle host read: issue, then check the returned data.
  task automatic rd_chk(input logic [7:0] a, input logic [31:0] e, input string tag);
    host_rd_req = 1'b1; host_rd_addr = a; #1;
    chk({tag, "_rdy"}, 32'(host_rd_ready), 32'd1);
    @(negedge clk);
    host_rd_req = 1'b0; #1;
    chk({tag, "_val"}, 32'(host_rd_valid), 32'd1);
    chk(tag, host_rd_data, e);
    @(negedge clk);
  endtask

  // Full sweep starting this cycle, then the clear_done cycle.
  task automatic sweep_chk(input string tag);
    for (int i = 0; i < 256; i++) begin
      #1;
      chk({tag, "_wen"}, 32'(ram_wen), 32'd1);
      chk({tag, "_waddr"}, 32'(ram_waddr), 32'(i));
      chk({tag, "_wdata"}, ram_wdata, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_incrdy"}, 32'(inc_ready), 32'd0);
      chk({tag, "_done_early"}, 32'(clear_done), 32'd0);
      @(negedge clk);
    end
    #1;
    chk({tag, "_done"}, 32'(clear_done), 32'd1);
    chk({tag, "_wen_after"}, 32'(ram_wen), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_incrdy_after"}, 32'(inc_ready), 32'd1);
    chk({tag, "_total"}, total_cnt, 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(clear_done), 32'd0);
  endtask

  initial begin
`ifdef HIST_SAT_EN
    sat_exp = 32'hFFFF_FFFF;
`else
    sat_exp = 32'd0;
`endif
    rst = 1'b1; inc_valid = 1'b0; inc_bin = 8'd0;
    host_rd_req = 1'b0; host_rd_addr = 8'd0; clear_start = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_inc_ready", 32'(inc_ready), 32'd0);
    chk("rst_host_rd_ready", 32'(host_rd_ready), 32'd0);
    chk("rst_host_rd_valid", 32'(host_rd_valid), 32'd0);
    chk("rst_host_rd_data", host_rd_data, 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_total_cnt", total_cnt, 32'd0);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_ram_raddr", 32'(ram_raddr), 32'd0);
    chk("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Initial clear straight from IDLE.
    clear_start = 1'b1; #1;
    chk("clr0_inc_ready", 32'(inc_ready), 32'd0);
    chk("clr0_host_rdy", 32'(host_rd_ready), 32'd0);
    @(negedge clk);
    clear_start = 1'b0;
    sweep_chk("clr0");

    // Five back-to-back increments of bin 7.
    for (int k = 0; k < 6; k++) begin
      inc_valid = (k < 5); inc_bin = 8'd7; #1;
      if (k < 5) begin
        chk("b2b_ready", 32'(inc_ready), 32'd1);
        chk("b2b_raddr", 32'(ram_raddr), 32'd7);
      end
      if (k > 0) begin
        chk("b2b_wen", 32'(ram_wen), 32'd1);
        chk("b2b_waddr", 32'(ram_waddr), 32'd7);
        chk("b2b_wdata", ram_wdata, 32'(k));
      end
      @(negedge clk);
    end
    #1;
    chk("b2b_total", total_cnt, 32'd5);
    chk("b2b_idle_wen", 32'(ram_wen), 32'd0);
    chk("b2b_hold_wdata", ram_wdata, 32'd5);
    rd_chk(8'd7, 32'd5, "b2b_rd7");

    // Alternating bins 3 and 4, ten increments.
    for (int k = 0; k < 10; k++) begin
      inc_valid = 1'b1; inc_bin = (k % 2 == 1) ? 8'd4 : 8'd3; #1;
      chk("alt_ready", 32'(inc_ready), 32'd1);
      @(negedge clk);
    end
    inc_valid = 1'b0;
    @(negedge clk);
    rd_chk(8'd3, 32'd5, "alt_rd3");
    rd_chk(8'd4, 32'd5, "alt_rd4");

    // Read wins over increment; then a read right behind an increment.
    host_rd_req = 1'b1; host_rd_addr = 8'd9; inc_valid = 1'b1; inc_bin = 8'd9; #1;
    chk("arb_host_rdy", 32'(host_rd_ready), 32'd1);
    chk("arb_inc_stall", 32'(inc_ready), 32'd0);
    chk("arb_raddr", 32'(ram_raddr), 32'd9);
    @(negedge clk);
    host_rd_req = 1'b0; #1;
    chk("arb_inc_ready", 32'(inc_ready), 32'd1);
    chk("arb_rd_valid", 32'(host_rd_valid), 32'd1);
    chk("arb_rd_data", host_rd_data, 32'd0);
    @(negedge clk);
    inc_valid = 1'b0; host_rd_req = 1'b1; host_rd_addr = 8'd9; #1;
    chk("fwd_wen", 32'(ram_wen), 32'd1);
    chk("fwd_wdata", ram_wdata, 32'd1);
    @(negedge clk);
    host_rd_req = 1'b0; #1;
    chk("fwd_rd_valid", 32'(host_rd_valid), 32'd1);
    chk("fwd_rd_data", host_rd_data, 32'd1);
    chk("fwd_total", total_cnt, 32'd16);
    @(negedge clk);

    // Clear requested while an increment sits in S1.
    inc_valid = 1'b1; inc_bin = 8'd5; #1;
    @(negedge clk);
    inc_valid = 1'b0; clear_start = 1'b1; #1;
    chk("drn_s1_wen", 32'(ram_wen), 32'd1);
    chk("drn_s1_waddr", 32'(ram_waddr), 32'd5);
    chk("drn_s1_wdata", ram_wdata, 32'd1);
    chk("drn_busy0", 32'(busy), 32'd1);
    chk("drn_inc_ready", 32'(inc_ready), 32'd0);
    @(negedge clk);
    clear_start = 1'b0; #1;
    chk("drn_wen", 32'(ram_wen), 32'd0);
    chk("drn_busy", 32'(busy), 32'd1);
    chk("drn_total", total_cnt, 32'd0);
    @(negedge clk);
    sweep_chk("clr1");
    rd_chk(8'd3, 32'd0, "clr1_rd3");
    rd_chk(8'd5, 32'd0, "clr1_rd5");
    rd_chk(8'd7, 32'd0, "clr1_rd7");
    rd_chk(8'd9, 32'd0, "clr1_rd9");

    // Bin at full scale.
    mem[2] = 32'hFFFF_FFFF;
    inc_valid = 1'b1; inc_bin = 8'd2; #1;
    @(negedge clk);
    inc_valid = 1'b0; #1;
    chk("sat_wen", 32'(ram_wen), 32'd1);
    chk("sat_wdata", ram_wdata, sat_exp);
    @(negedge clk);
    rd_chk(8'd2, sat_exp, "sat_rd2");
    #1;
    chk("sat_total", total_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
